// File: rtl/pp_rally_if.sv
// Player/scoreboard bundle for the two-ball rally referee.
// The master drives requests and declines; the referee (slave) answers with grants and scores.
interface pp_rally_if #(
    parameter int CNT_W = 8
);
    logic             req_a;
    logic             req_b;
    logic             miss_a;
    logic             miss_b;
    logic             hit_a;
    logic             hit_b;
    logic [1:0]       ball1_st;
    logic [1:0]       ball2_st;
    logic [1:0]       balls_in_play;
    logic [CNT_W-1:0] rally_cnt;
    logic             point_a;
    logic             point_b;
    logic [3:0]       score_a;
    logic [3:0]       score_b;

    modport master (
        output req_a, req_b, miss_a, miss_b,
        input  hit_a, hit_b, ball1_st, ball2_st, balls_in_play,
        input  rally_cnt, point_a, point_b, score_a, score_b
    );

    modport slave (
        input  req_a, req_b, miss_a, miss_b,
        output hit_a, hit_b, ball1_st, ball2_st, balls_in_play,
        output rally_cnt, point_a, point_b, score_a, score_b
    );
endinterface

// File: rtl/pp_rally_referee.sv
// Two-ball ping-pong referee: owns ball states, grants hits,
// times out idle players, scores declines and restarts rallies.
module pp_rally_referee #(
    parameter int MAX_WAIT    = 7,
    parameter int CNT_W       = 8,
    parameter int RALLY_LIMIT = 20,
    parameter int SERVE_GAP   = 2
) (
    input logic       clk,
    input logic       reset,
    pp_rally_if.slave bus
);
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int GW = (SERVE_GAP > 1) ? $clog2(SERVE_GAP + 1) : 1;

    localparam logic [1:0] TO_A = 2'b00;
    localparam logic [1:0] TO_B = 2'b01;
    localparam logic [1:0] OUT  = 2'b10;

    typedef enum logic [1:0] {
        S_SERVE,
        S_RALLY2,
        S_RALLY1,
        S_GAP
    } state_t;

    state_t state, state_d;

    logic             hit_a, hit_b, pt_a, pt_b;
    logic [1:0]       ball1, ball2, bip;
    logic [CNT_W-1:0] rcnt;
    logic [3:0]       sc_a, sc_b;
    logic [WW-1:0]    wait_cnt;
    logic [GW-1:0]    gap_cnt;

    logic             hit_a_d, hit_b_d, pt_a_d, pt_b_d;
    logic [1:0]       ball1_d, ball2_d, bip_d;
    logic [CNT_W-1:0] rcnt_d;
    logic [3:0]       sc_a_d, sc_b_d;
    logic [WW-1:0]    wait_d;
    logic [GW-1:0]    gap_d;

    logic             one_miss, wait_max, both_go, lone_go;
    logic             any_hit, rally_end;
    logic [1:0]       lone, loser;
    logic [CNT_W-1:0] rcnt_inc;

    function automatic logic [1:0] flip(input logic [1:0] s);
        case (s)
            TO_A:    return TO_B;
            TO_B:    return TO_A;
            default: return OUT;
        endcase
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

    assign one_miss = bus.miss_a ^ bus.miss_b;
    assign wait_max = (wait_cnt == WW'(MAX_WAIT));
    assign both_go  = (bus.req_a & bus.req_b) | wait_max;
    assign lone     = (ball1 != OUT) ? ball1 : ball2;
    assign lone_go  = ((lone == TO_A) ? bus.req_a : bus.req_b) | wait_max;
    assign loser    = bus.miss_a ? TO_A : TO_B;
    assign rcnt_inc = (rcnt == '1) ? rcnt : rcnt + CNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_SERVE;
        else       state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            S_SERVE:  state_d = S_RALLY2;
            S_RALLY2: begin
                if (rally_end)     state_d = S_GAP;
                else if (one_miss) state_d = S_RALLY1;
            end
            S_RALLY1: begin
                if (rally_end) state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == GW'(SERVE_GAP - 1)) state_d = S_SERVE;
            end
        endcase
    end

    // Output / datapath next values
    always_comb begin
        hit_a_d = 1'b0;
        hit_b_d = 1'b0;
        pt_a_d  = 1'b0;
        pt_b_d  = 1'b0;
        ball1_d = ball1;
        ball2_d = ball2;
        rcnt_d  = rcnt;
        sc_a_d  = sc_a;
        sc_b_d  = sc_b;
        wait_d  = wait_cnt;
        gap_d   = gap_cnt;
        any_hit = 1'b0;

        unique case (state)
            S_SERVE: begin
                ball1_d = TO_A;
                ball2_d = TO_B;
                rcnt_d  = '0;
                wait_d  = '0;
            end
            S_RALLY2: begin
                if (one_miss) begin
                    // decliner's ball dies, the other is returned to the decliner
                    hit_a_d = bus.miss_b;
                    hit_b_d = bus.miss_a;
                    pt_a_d  = bus.miss_b;
                    pt_b_d  = bus.miss_a;
                    if (bus.miss_a) sc_b_d = sat_inc4(sc_b);
                    else            sc_a_d = sat_inc4(sc_a);
                    ball1_d = (ball1 == loser) ? OUT : loser;
                    ball2_d = (ball2 == loser) ? OUT : loser;
                    any_hit = 1'b1;
                    wait_d  = '0;
                end else if (both_go) begin
                    hit_a_d = 1'b1;
                    hit_b_d = 1'b1;
                    ball1_d = flip(ball1);
                    ball2_d = flip(ball2);
                    any_hit = 1'b1;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_cnt + WW'(1);
                end
            end
            S_RALLY1: begin
                if (lone_go) begin
                    hit_a_d = (lone == TO_A);
                    hit_b_d = (lone == TO_B);
                    ball1_d = flip(ball1);
                    ball2_d = flip(ball2);
                    any_hit = 1'b1;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_cnt + WW'(1);
                end
            end
            S_GAP: begin
                gap_d = gap_cnt + GW'(1);
            end
        endcase

        if (any_hit) rcnt_d = rcnt_inc;
        if (rally_end) begin
            ball1_d = OUT;
            ball2_d = OUT;
            gap_d   = '0;
        end
    end

    assign rally_end = any_hit & (rcnt_inc == CNT_W'(RALLY_LIMIT));
    assign bip_d     = 2'(ball1_d != OUT) + 2'(ball2_d != OUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_a    <= 1'b0;
            hit_b    <= 1'b0;
            pt_a     <= 1'b0;
            pt_b     <= 1'b0;
            ball1    <= OUT;
            ball2    <= OUT;
            bip      <= 2'd0;
            rcnt     <= '0;
            sc_a     <= 4'd0;
            sc_b     <= 4'd0;
            wait_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            hit_a    <= hit_a_d;
            hit_b    <= hit_b_d;
            pt_a     <= pt_a_d;
            pt_b     <= pt_b_d;
            ball1    <= ball1_d;
            ball2    <= ball2_d;
            bip      <= bip_d;
            rcnt     <= rcnt_d;
            sc_a     <= sc_a_d;
            sc_b     <= sc_b_d;
            wait_cnt <= wait_d;
            gap_cnt  <= gap_d;
        end
    end

    assign bus.hit_a         = hit_a;
    assign bus.hit_b         = hit_b;
    assign bus.ball1_st      = ball1;
    assign bus.ball2_st      = ball2;
    assign bus.balls_in_play = bip;
    assign bus.rally_cnt     = rcnt;
    assign bus.point_a       = pt_a;
    assign bus.point_b       = pt_b;
    assign bus.score_a       = sc_a;
    assign bus.score_b       = sc_b;
endmodule

// File: tb/tb_pp_rally_referee.sv
// Scoreboard bench for pp_rally_referee: a rule-level game model
// predicts every cycle's outputs; a monitor pops and compares.
module tb_pp_rally_referee;
    localparam int MW  = 7;
    localparam int LIM = 4;
    localparam int SG  = 2;

    localparam int P_SERVE = 0;
    localparam int P_R2    = 1;
    localparam int P_R1    = 2;
    localparam int P_GAP   = 3;

    typedef struct packed {
        logic       ha;
        logic       hb;
        logic [1:0] b1;
        logic [1:0] b2;
        logic [1:0] bip;
        logic [7:0] rc;
        logic       pa;
        logic       pb;
        logic [3:0] sa;
        logic [3:0] sb;
        logic [2:0] w;
        logic [1:0] ph;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    pp_rally_if #(.CNT_W(8)) bus ();

    pp_rally_referee #(
        .MAX_WAIT(MW),
        .CNT_W(8),
        .RALLY_LIMIT(LIM),
        .SERVE_GAP(SG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // game model: directions 0 = toward A, 1 = toward B, 2 = dead
    int ph = P_SERVE;
    int bl[2] = '{2, 2};
    int rc = 0, w = 0, g = 0, sa = 0, sb = 0;
    bit ha, hb, pa, pb;

    task automatic model(input bit ra, rb, ma, mb, rst);
        bit hit;
        int lo, x;
        hit = 0;
        ha = 0; hb = 0; pa = 0; pb = 0;
        if (rst) begin
            ph = P_SERVE; bl = '{2, 2};
            rc = 0; w = 0; g = 0; sa = 0; sb = 0;
            return;
        end
        case (ph)
            P_SERVE: begin
                bl = '{0, 1}; rc = 0; w = 0; ph = P_R2;
            end
            P_R2: begin
                if (ma != mb) begin
                    lo = ma ? 0 : 1;
                    foreach (bl[i]) bl[i] = (bl[i] == lo) ? 2 : lo;
                    if (ma) begin hb = 1; pb = 1; sb = (sb < 15) ? sb + 1 : 15; end
                    else    begin ha = 1; pa = 1; sa = (sa < 15) ? sa + 1 : 15; end
                    hit = 1; w = 0; ph = P_R1;
                end else if ((ra && rb) || w == MW) begin
                    ha = 1; hb = 1;
                    foreach (bl[i]) bl[i] = 1 - bl[i];
                    hit = 1; w = 0;
                end else w++;
            end
            P_R1: begin
                x = (bl[0] != 2) ? bl[0] : bl[1];
                if ((x == 0 ? ra : rb) || w == MW) begin
                    if (x == 0) ha = 1; else hb = 1;
                    foreach (bl[i]) if (bl[i] != 2) bl[i] = 1 - bl[i];
                    hit = 1; w = 0;
                end else w++;
            end
            default: begin
                g++;
                if (g == SG) ph = P_SERVE;
            end
        endcase
        if (hit) begin
            if (rc < 255) rc++;
            if (rc == LIM) begin bl = '{2, 2}; g = 0; ph = P_GAP; end
        end
    endtask

    task automatic step(input bit ra, rb, ma, mb, rst);
        exp_t e;
        int   nb;
        @(negedge clk);
        bus.req_a = ra; bus.req_b = rb;
        bus.miss_a = ma; bus.miss_b = mb;
        reset = rst;
        model(ra, rb, ma, mb, rst);
        nb = (bl[0] != 2 ? 1 : 0) + (bl[1] != 2 ? 1 : 0);
        e = '{ha: ha, hb: hb, b1: 2'(bl[0]), b2: 2'(bl[1]), bip: 2'(nb),
               rc: 8'(rc), pa: pa, pb: pb, sa: 4'(sa), sb: 4'(sb),
               w: 3'(w), ph: 2'(ph)};
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Monitor: one expectation per clock edge
    initial begin
        exp_t e, a;
        logic [1:0] pb1, pb2, pbip;
        pb1 = 2; pb2 = 2; pbip = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{ha: bus.hit_a, hb: bus.hit_b, b1: bus.ball1_st,
                       b2: bus.ball2_st, bip: bus.balls_in_play,
                       rc: bus.rally_cnt, pa: bus.point_a, pb: bus.point_b,
                       sa: bus.score_a, sb: bus.score_b,
                       w: dut.wait_cnt, ph: e.ph};
                n_chk++;
                if (a == e) n_pass++;
                else $display("FAIL outputs t=%0t got hit=%b%b b=%0d/%0d bip=%0d rc=%0d pt=%b%b sc=%0d/%0d w=%0d exp hit=%b%b b=%0d/%0d bip=%0d rc=%0d pt=%b%b sc=%0d/%0d w=%0d",
                    $time, a.ha, a.hb, a.b1, a.b2, a.bip, a.rc, a.pa, a.pb, a.sa, a.sb, a.w,
                    e.ha, e.hb, e.b1, e.b2, e.bip, e.rc, e.pa, e.pb, e.sa, e.sb, e.w);
                n_chk++;
                if (a.b1 == 2'd2 || a.b1 != a.b2) n_pass++;
                else $display("FAIL same_dir got b=%0d/%0d required distinct", a.b1, a.b2);
                n_chk++;
                if ((!a.ha || pb1 == 0 || pb2 == 0) && (!a.hb || pb1 == 1 || pb2 == 1)) n_pass++;
                else $display("FAIL hit_dir got hit=%b%b prev b=%0d/%0d", a.ha, a.hb, pb1, pb2);
                n_chk++;
                if (pbip != 2 || a.ha == a.hb || a.pa || a.pb) n_pass++;
                else $display("FAIL partial_hit got hit=%b%b pt=%b%b required miss point", a.ha, a.hb, a.pa, a.pb);
                n_chk++;
                if (a.w <= MW) n_pass++;
                else $display("FAIL wait_bound got %0d required <= %0d", a.w, MW);
                n_chk++;
                if (a.bip != 1 || e.ph == P_R1) n_pass++;
                else $display("FAIL one_ball_state got phase %0d required %0d", e.ph, P_R1);
                pb1 = a.b1; pb2 = a.b2; pbip = a.bip;
            end
        end
    end

    initial begin
        int n;
        bus.req_a = 0; bus.req_b = 0; bus.miss_a = 0; bus.miss_b = 0;
        // serve
        step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
        idle(1);
        // simultaneous hit, then lone req held off
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
        // timeout from a fresh serve
        step(0, 0, 0, 0, 1); idle(1);
        idle(8);
        // decline, then ignored miss in single-ball play
        step(0, 0, 0, 0, 1); idle(1);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        // drive to the rally limit, gap, serve
        step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        idle(5);
        // both misses with both reqs: plain double hit
        step(1, 1, 1, 1, 0);
        // reset in single-ball play
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        // score saturation for B
        for (int r = 0; r < 17; r++) begin
            n = 0;
            while (ph != P_R2 && n < 100) begin idle(1); n++; end
            step(0, 0, 1, 0, 0);
        end
        idle(40);
        // randomized play
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 299) == 0));
        end
        @(posedge clk);
        #3;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending required 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pp_rally_referee.md
Name: pp_rally_referee

Overview:
- Referee and scheduler for the two-ball ping-pong game.
- Owns both ball states and grants HIT actions to players A and B.
- Enforces the game rules: in the two-ball phase both hits are simultaneous; at most one player may decline; a single ball stays in play; every wait is bounded.
- Scores points and restarts rallies. Sits between player request logic and the scoreboard.

Parameters:
MAX_WAIT, 7, idle cycles allowed in a rally state before a hit is forced (>=1)
CNT_W, 8, width of rally_cnt
RALLY_LIMIT, 20, rally_cnt value that ends a rally (1..2^CNT_W-1)
SERVE_GAP, 2, idle cycles between rally end and next serve (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
req_a  in  1  player A ready to hit ball coming to A
req_b  in  1  player B ready to hit ball coming to B
miss_a  in  1  player A declines ball (honoured only in RALLY2)
miss_b  in  1  player B declines ball (honoured only in RALLY2)
hit_a  out  1  registered one-cycle HIT grant to A
hit_b  out  1  registered one-cycle HIT grant to B
ball1_st  out  2  00 TO_A, 01 TO_B, 10 OUT_OF_PLAY
ball2_st  out  2  same encoding
balls_in_play  out  2  count of balls not OUT (0..2)
rally_cnt  out  CNT_W  hit events in current rally
point_a  out  1  one-cycle pulse, A scores
point_b  out  1  one-cycle pulse, B scores
score_a  out  4  A points, saturating at 15
score_b  out  4  B points, saturating at 15

Behaviour:
- Reset (sync, wins over everything):
  - state=SERVE; ball1_st=ball2_st=OUT; balls_in_play=0.
  - hit_*, point_* =0; rally_cnt, wait_cnt, gap_cnt, scores =0.
  - Reset mid-rally discards the rally; scores are also cleared.
- All outputs are registered. A hit grant and its ball update appear on the same edge. Decisions use the inputs sampled at that edge. Latency from req to hit is 1 cycle.
- SERVE (1 cycle): ball1=TO_A, ball2=TO_B, rally_cnt=0, wait_cnt=0 -> RALLY2.
- RALLY2 (both balls in play, one coming to each player), priority order:
  1. Exactly one miss asserted (say miss_a): hit_b=1, hit_a=0; ball coming to A -> OUT, ball coming to B -> TO_A; point_b pulse; score_b+1 saturating; rally_cnt+1; -> RALLY1. miss_b is symmetric.
  2. Both miss asserted: both ignored this cycle; evaluate as rule 3.
  3. (req_a && req_b) or wait_cnt==MAX_WAIT: hit_a=hit_b=1; both balls flip direction; rally_cnt+1; wait_cnt=0.
  4. Otherwise no hit and wait_cnt+1. A lone req is held off; no partial hit is ever granted.
- RALLY1 (one ball, direction X; miss_* ignored):
  - If req_X or wait_cnt==MAX_WAIT: hit_X=1, ball flips, rally_cnt+1, wait_cnt=0.
  - req from the non-X player is ignored. Otherwise wait_cnt+1.
- Rally end: a hit that makes rally_cnt==RALLY_LIMIT, in either rally state, ends the rally.
  - On that same edge all balls -> OUT and gap_cnt=0; -> GAP. No point is awarded.
  - This check takes precedence over the RALLY2->RALLY1 transition when both occur on the same hit; the point from a miss is still awarded.
- GAP: no hits; gap_cnt+1 per cycle; after SERVE_GAP cycles -> SERVE.
- rally_cnt saturates at 2^CNT_W-1. wait_cnt is wide enough for MAX_WAIT and never exceeds it.
- Invariants (assert in bench):
  - Never two balls in the same direction.
  - hit_x only when a ball was coming to x.
  - In RALLY2, hit_a != hit_b only on a miss cycle.
  - wait_cnt <= MAX_WAIT.
  - balls_in_play==1 implies state RALLY1.

Test Plan:
1. Serve: reset high 2 cycles, then low -> next edge ball1_st=00, ball2_st=01, balls_in_play=2, rally_cnt=0, all hits 0.
2. Simultaneous hit: in RALLY2 drive req_a=req_b=1 for one cycle -> hit_a=hit_b=1 for exactly 1 cycle, ball1_st=01, ball2_st=00, rally_cnt=1. A lone req_a held 3 cycles -> no hit, wait_cnt=3.
3. Timeout, MAX_WAIT=7: no reqs in RALLY2 -> no hit for 7 edges, forced hit_a=hit_b=1 on the 8th edge, wait_cnt back to 0.
4. Decline: from serve state, miss_a=1, req_b=1 -> hit_b=1, hit_a=0, ball1_st=10, ball2_st=00, point_b pulse, score_b=1, balls_in_play=1. Then miss_b=1 in RALLY1 -> ignored, no point.
5. Limit, RALLY_LIMIT=4, SERVE_GAP=2: four hits -> on the 4th hit edge balls=10/10, balls_in_play=0; 2 GAP cycles; SERVE; RALLY2 with rally_cnt=0 and scores retained.
6. Corners:
   - miss_a=miss_b=1 with req_a=req_b=1 -> normal double hit, no point.
   - reset asserted mid-RALLY1 -> next edge all outputs at reset values.
   - score_b=15 plus another miss_a -> point_b pulses, score_b stays 15.
